serial_adder: RTL

- Bit-serial WIDTH-bit unsigned adder; the addition counterpart to the team's subtractor blocks.
- Processes operands LSB-first, one bit per clock, through a single full-adder cell and a registered carry.
- Used where area matters more than latency, and as a sequential reference for the combinational add/subtract library.
- Uses a start/ready/done handshake with registered, held results.

---
 rtl/serial_adder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit unsigned adder.
// One full-adder cell and a registered carry process the operands LSB-first,
// one bit per clock. A start/ready/done handshake frames each operation and
// the result (sum, cout) is registered and held until the next completion.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request to begin an addition, sampled only while ready=1
//   a, b   WIDTH-bit operands, captured on the accepted start edge
//   ready  high while idle (start can be accepted)
//   busy   high while bits are being processed
//   done   one-cycle pulse; sum/cout valid from this cycle onward
//   sum    registered a+b mod 2^WIDTH
//   cout   registered carry out of bit WIDTH-1
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   shift_a;
    logic [WIDTH-1:0]   shift_b;
    logic [WIDTH-1:0]   acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               bit_sum_c;
    logic               bit_carry_c;
    logic               last_bit_c;
    logic [WIDTH-1:0]   acc_nxt_c;

    // Full-adder cell on the current LSBs and the running carry.
    always_comb begin
        bit_sum_c   = shift_a[0] ^ shift_b[0] ^ carry;
        bit_carry_c = (shift_a[0] & shift_b[0]) |
                      (shift_a[0] & carry)      |
                      (shift_b[0] & carry);
        last_bit_c  = (cnt == LAST_CNT);
        // New sum bit enters at the MSB so after WIDTH shifts bit 0 is the LSB.
        acc_nxt_c   = {bit_sum_c, acc[WIDTH-1:1]};
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit_c) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and registered status outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == ST_IDLE);
            busy  <= (state_nxt == ST_RUN);
            done  <= (state_nxt == ST_DONE);
        end
    end

    // Datapath: operand capture, bit-serial add, result update on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_a <= a;
                        shift_b <= b;
                        acc     <= '0;
                        carry   <= 1'b0;
                        cnt     <= '0;
                    end
                end
                ST_RUN: begin
                    shift_a <= {1'b0, shift_a[WIDTH-1:1]};
                    shift_b <= {1'b0, shift_b[WIDTH-1:1]};
                    acc     <= acc_nxt_c;
                    carry   <= bit_carry_c;
                    cnt     <= cnt + CNT_W'(1);
                    // Result registers move only on the completing edge.
                    if (last_bit_c) begin
                        sum  <= acc_nxt_c;
                        cout <= bit_carry_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
